// File: rtl/word_loader.sv
// word_loader: splits a valid/ready character stream into zero-terminated words in the word SRAM.
// Ports: clk, rst_n, start, in_* handshake, mem_we/addr/din, word_count, overflow, done. Option: LOWERCASE_EN.
module word_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEP_CHAR = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  overflow,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CLOSE, ENDW, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WC_MAX = '1;
  // Last address a character may use; keeps room for the closing and list zeros.
  localparam logic [ADDR_WIDTH-1:0] CHAR_MAX =
    ADDR_WIDTH'((2 ** ADDR_WIDTH) - 3);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic                  open_q, open_d;
  logic [ADDR_WIDTH-1:0] wc_q, wc_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic                  is_sep;
  logic [DATA_WIDTH-1:0] char_w;
  logic [ADDR_WIDTH-1:0] wc_inc;

  assign is_sep = (in_data == SEP_CHAR) || (in_data == '0);
  assign wc_inc = (wc_q == WC_MAX) ? wc_q : wc_q + 1'b1;

`ifdef LOWERCASE_EN
  assign char_w =
    ((in_data >= DATA_WIDTH'(8'h41)) && (in_data <= DATA_WIDTH'(8'h5A)))
      ? in_data + DATA_WIDTH'(8'h20) : in_data;
`else
  assign char_w = in_data;
`endif

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    open_d  = open_q;
    wc_d    = wc_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          wp_d    = '0;
          open_d  = 1'b0;
          wc_d    = '0;
          ovf_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (is_sep) begin
            if (open_q) begin
              we_d   = 1'b1;
              addr_d = wp_q;
              din_d  = '0;
              wp_d   = wp_q + 1'b1;
              open_d = 1'b0;
              wc_d   = wc_inc;
            end
          end else if (wp_q <= CHAR_MAX) begin
            we_d   = 1'b1;
            addr_d = wp_q;
            din_d  = char_w;
            wp_d   = wp_q + 1'b1;
            open_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) state_d = CLOSE;
        end
      end
      CLOSE: begin
        // Empty stream still needs one word-closing zero ahead of the list end.
        if (open_q || (wc_q == '0)) begin
          we_d   = 1'b1;
          addr_d = wp_q;
          din_d  = '0;
          wp_d   = wp_q + 1'b1;
        end
        if (open_q) wc_d = wc_inc;
        open_d  = 1'b0;
        state_d = ENDW;
      end
      ENDW: begin
        we_d    = 1'b1;
        addr_d  = wp_q;
        din_d   = '0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wp_q    <= '0;
      open_q  <= 1'b0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      open_q  <= open_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign word_count = wc_q;
  assign overflow   = ovf_q;
  assign done       = done_q;

endmodule
